// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//   Definitions shared by the program loader, the CPU control unit and the
//   host-side loader tooling.
//
//   Contents:
//     ADDR_W_DEFAULT : default instruction-memory address width.
//     state_e        : loader FSM state encoding (3 bits).
//     INSN_*         : bit positions of the instruction fields
//                      opcode[7:6], funct[5:4], a2[3:2], a1[1:0].
//     insn_*()       : field extractors built on those positions.
//     len_is_legal() : checks a length byte against the memory capacity.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  // Capacity is 2**ADDR_W bytes. The length byte is 8 bits wide, so widths
  // above 8 cannot be addressed by a single load.
  localparam int ADDR_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_e;

  // One instruction is one byte.
  localparam int INSN_OPCODE_MSB = 7;
  localparam int INSN_OPCODE_LSB = 6;
  localparam int INSN_FUNCT_MSB  = 5;
  localparam int INSN_FUNCT_LSB  = 4;
  localparam int INSN_A2_MSB     = 3;
  localparam int INSN_A2_LSB     = 2;
  localparam int INSN_A1_MSB     = 1;
  localparam int INSN_A1_LSB     = 0;

  function automatic logic [1:0] insn_opcode(input logic [7:0] insn);
    return insn[INSN_OPCODE_MSB:INSN_OPCODE_LSB];
  endfunction

  function automatic logic [1:0] insn_funct(input logic [7:0] insn);
    return insn[INSN_FUNCT_MSB:INSN_FUNCT_LSB];
  endfunction

  function automatic logic [1:0] insn_a2(input logic [7:0] insn);
    return insn[INSN_A2_MSB:INSN_A2_LSB];
  endfunction

  function automatic logic [1:0] insn_a1(input logic [7:0] insn);
    return insn[INSN_A1_MSB:INSN_A1_LSB];
  endfunction

  // A legal length is 1 .. 2**addr_w inclusive. The comparison is made in
  // 9 bits so that a capacity of 256 (addr_w = 8) is still representable.
  function automatic logic len_is_legal(input logic [7:0] len,
                                        input int unsigned addr_w);
    logic [8:0] capacity;
    capacity = 9'(1 << addr_w);
    return (len != 8'd0) && ({1'b0, len} <= capacity);
  endfunction

endpackage : prog_loader_pkg

// File: rtl/loader_csum.sv
// -----------------------------------------------------------------------------
// loader_csum
//   8-bit XOR accumulator for the program checksum.
//
//   Ports:
//     clk      in   system clock, rising edge
//     clr      in   synchronous active-high reset, clears the accumulator
//     clear_i  in   restart the accumulation (takes priority over en_i)
//     en_i     in   fold data_i into the accumulator this cycle
//     data_i   in   byte to accumulate
//     csum_o   out  current accumulator value
// -----------------------------------------------------------------------------
module loader_csum (
  input  logic       clk,
  input  logic       clr,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q;
  logic [7:0] csum_d;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = 8'h00;
    end else if (en_i) begin
      csum_d = csum_q ^ data_i;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule : loader_csum

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writes a program received as a byte stream into instruction memory,
//   starting at address 0, and holds the CPU core in reset until the program
//   has been loaded and its XOR checksum verified.
//
//   Stream format:  L, B0 .. B(L-1), C   where C = B0 ^ B1 ^ ... ^ B(L-1)
//
//   Ports:
//     clk        in   system clock, rising edge
//     clr        in   synchronous active-high reset
//     start      in   load request (one-cycle pulse), ignored while busy
//     in_data    in   stream byte
//     in_valid   in   in_data valid
//     in_ready   out  a byte is accepted this cycle (LEN, DATA or CSUM)
//     mem_we     out  instruction-memory write enable, one pulse per byte
//     mem_addr   out  write address
//     mem_wdata  out  write data (one instruction)
//     cpu_clr_n  out  active-low CPU reset; 1 only in RUN
//     busy       out  load in progress (LEN, DATA, CSUM)
//     done       out  one-cycle pulse in the first RUN cycle
//     error      out  sticky error flag, cleared by the next start
//
//   All outputs except in_ready are registered; each one is loaded on the
//   same edge as the state transition that defines it, so they line up with
//   the state register rather than lagging it by a cycle.
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_clr_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q;
  logic [7:0]        len_q;
  logic [7:0]        count_q;
  logic [7:0]        count_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              cpu_clr_n_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              csum_clear;
  logic              csum_en;
  logic [7:0]        csum_value;

  // The stream is only consumed in the three loading states; in_valid at any
  // other time is left pending on the host side.
  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign accept   = in_valid && in_ready;

  // The accumulator restarts when the length byte is taken and folds in
  // every program byte; the checksum byte itself is only compared.
  assign csum_clear = (state_q == LEN)  && accept;
  assign csum_en    = (state_q == DATA) && accept;

  // Number of program bytes accepted once the current one is counted.
  assign count_d = count_q + 8'd1;

  loader_csum u_csum (
    .clk     (clk),
    .clr     (clr),
    .clear_i (csum_clear),
    .en_i    (csum_en),
    .data_i  (in_data),
    .csum_o  (csum_value)
  );

  // NOTE: only control and datapath registers are reset here; the program
  // image lives in the instruction memory, which is never cleared by reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      count_q     <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      cpu_clr_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Pulsed outputs fall back to 0 unless a branch below raises them.
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LEN;
            busy_q  <= 1'b1;
          end
        end

        LEN: begin
          if (accept) begin
            if (len_is_legal(in_data, ADDR_W)) begin
              len_q   <= in_data;
              count_q <= 8'd0;
              state_q <= DATA;
            end else begin
              state_q <= ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end

        DATA: begin
          if (accept) begin
            // count_q < len_q <= 2**ADDR_W here, so the low ADDR_W bits are
            // the full address and the write address never wraps.
            mem_we_q    <= 1'b1;
            mem_addr_q  <= count_q[ADDR_W-1:0];
            mem_wdata_q <= in_data;
            count_q     <= count_d;
            if (count_d == len_q) begin
              state_q <= CSUM;
            end
          end
        end

        CSUM: begin
          if (accept) begin
            busy_q <= 1'b0;
            if (in_data == csum_value) begin
              state_q     <= RUN;
              done_q      <= 1'b1;
              cpu_clr_n_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end

        RUN: begin
          // A reload puts the CPU back into reset before any byte is written.
          if (start) begin
            state_q     <= LEN;
            busy_q      <= 1'b1;
            cpu_clr_n_q <= 1'b0;
          end
        end

        ERR: begin
          if (start) begin
            state_q <= LEN;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cpu_clr_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_clr_n = cpu_clr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader (ADDR_W = 5). A reference model turns
//   each generated stream into the expected list of memory writes and the
//   expected final flags; a monitor collects the writes and done pulses the
//   DUT actually produces.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int ADDR_W = 5;
  localparam int CAP    = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_clr_n;
  logic              busy;
  logic              done;
  logic              error;

  int total = 0;
  int bad   = 0;

  wr_t wr_q[$];
  int  done_seen;
  int  done_with_run;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_clr_n (cpu_clr_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Outputs are sampled on the falling edge, half a cycle away from updates.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{addr: mem_addr, data: mem_wdata});
    if (done) begin
      done_seen++;
      if (cpu_clr_n) done_with_run++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    wr_q.delete();
    done_seen     = 0;
    done_with_run = 0;
  endtask

  task automatic do_reset();
    clr      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) tick();
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 0..gap idle cycles and hold it until accepted.
  // in_ready is read before the edge, so acceptance is decided exactly.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit acc;
    int n;
    in_valid = 1'b0;
    repeat ($urandom_range(0, gap)) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 64) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: a legal length yields one write per program byte at
  // consecutive addresses from 0, and the load succeeds only if the final
  // byte equals the XOR of all program bytes.
  task automatic load_and_check(input string tag, input bit do_start, input logic [7:0] len,
                                input bq_t prog, input logic [7:0] csum, input int gap,
                                input int start_at);
    logic [7:0] x;
    bit         len_ok;
    bit         ok;
    int         n_exp;
    x      = 8'h00;
    len_ok = (len != 8'd0) && (int'(len) <= CAP);
    foreach (prog[i]) x ^= prog[i];
    ok     = len_ok && (csum == x);
    n_exp  = len_ok ? prog.size() : 0;

    clear_monitor();
    if (do_start) pulse_start();
    check({tag, "_busy_start"}, busy, 1);
    send_byte(len, gap, 1'b0);
    if (len_ok) begin
      foreach (prog[i]) send_byte(prog[i], gap, (i == start_at));
      send_byte(csum, gap, 1'b0);
    end
    repeat (3) tick();

    check({tag, "_nwr"}, wr_q.size(), n_exp);
    if (wr_q.size() == n_exp) begin
      for (int i = 0; i < n_exp; i++) begin
        check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
        check($sformatf("%s_data%0d", tag, i), wr_q[i].data, prog[i]);
      end
    end
    check({tag, "_done"},     done_seen, ok ? 1 : 0);
    check({tag, "_done_run"}, done_with_run, ok ? 1 : 0);
    check({tag, "_error"},    error, !ok);
    check({tag, "_cpu_clr_n"}, cpu_clr_n, ok);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ready_end"}, in_ready, 0);
  endtask

  initial begin
    bq_t        prog;
    logic [7:0] x;
    int         len;
    int         gap;
    int         sat;

    do_reset();
    clear_monitor();

    // Reset state.
    check("rst_mem_we",    mem_we, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_clr_n", cpu_clr_n, 0);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_error",     error, 0);
    check("rst_in_ready",  in_ready, 0);

    // in_valid in IDLE is ignored.
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    check("idle_valid_nwr",  wr_q.size(), 0);
    check("idle_valid_busy", busy, 0);

    // Directed good load.
    prog = '{8'h4D, 8'h92, 8'hC1};
    load_and_check("good", 1'b1, 8'h03, prog, 8'h1E, 0, -1);

    // start in RUN drops cpu_clr_n on the next cycle, then reload.
    pulse_start();
    check("run_start_cpu_clr_n", cpu_clr_n, 0);
    check("run_start_busy",      busy, 1);
    check("run_start_ready",     in_ready, 1);
    load_and_check("reload", 1'b0, 8'h03, prog, 8'h1E, 0, -1);

    // Bad checksum, then start clears the sticky error.
    load_and_check("badcsum", 1'b1, 8'h03, prog, 8'h1F, 0, -1);
    pulse_start();
    check("err_start_error", error, 0);
    check("err_start_busy",  busy, 1);
    load_and_check("after_err", 1'b0, 8'h03, prog, 8'h1E, 0, -1);

    // Bad lengths.
    prog = {};
    load_and_check("len0",  1'b1, 8'h00, prog, 8'h00, 0, -1);
    load_and_check("len33", 1'b1, 8'h21, prog, 8'h00, 0, -1);

    // Gapped stream with a start pulse injected during DATA.
    prog = {};
    for (int i = 0; i < 7; i++) prog.push_back(8'($urandom));
    x = 8'h00;
    foreach (prog[i]) x ^= prog[i];
    load_and_check("gaps", 1'b1, 8'd7, prog, x, 3, 2);

    // Full-capacity load, addresses 0..31.
    prog = {};
    for (int i = 0; i < CAP; i++) prog.push_back(8'($urandom));
    x = 8'h00;
    foreach (prog[i]) x ^= prog[i];
    load_and_check("full", 1'b1, 8'(CAP), prog, x, 0, -1);

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      prog = {};
      if ($urandom_range(0, 5) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(CAP + 1, 255);
      end else begin
        len = $urandom_range(1, CAP);
        for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      end
      x = 8'h00;
      foreach (prog[i]) x ^= prog[i];
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      gap = $urandom_range(0, 2);
      sat = (prog.size() > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, prog.size() - 1) : -1;
      load_and_check($sformatf("rnd%0d", t), 1'b1, 8'(len), prog, x, gap, sat);
    end

    // Reset after 2 of 3 data bytes.
    clear_monitor();
    pulse_start();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("midrst_mem_we",    mem_we, 0);
    check("midrst_busy",      busy, 0);
    check("midrst_cpu_clr_n", cpu_clr_n, 0);
    check("midrst_ready",     in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (2) tick();
    in_valid = 1'b0;
    check("midrst_nwr", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("midrst_addr1", wr_q[1].addr, 1);
      check("midrst_data1", wr_q[1].data, 8'h5A);
    end

    // clr and start together: reset wins.
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    check("clr_start_busy",  busy, 0);
    check("clr_start_ready", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory that the multicycle CPU control unit reads during Fetch.
- Accepts a byte stream holding a length, the program bytes and a checksum, and writes the program into instruction memory from address 0.
- Holds the CPU in reset while loading and releases it only after the checksum passes.
- Sits between the host/UART byte interface and the instruction-memory write port, and drives the CPU core's clr_n.

Parameters:
- ADDR_W, 5, instruction-memory address width; capacity 2**ADDR_W bytes.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  load request, one-cycle pulse.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data (one instruction).
- cpu_clr_n  out  1  active-low reset to the CPU core; 0 holds the CPU.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes OK.
- error  out  1  sticky; set on bad length or checksum mismatch.

Behaviour:
- Reset (clr=1 at a rising edge):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_clr_n=0, busy=0, done=0, error=0.
  - Byte count, length and checksum registers cleared.
- All outputs are registered, except in_ready = (state is LEN, DATA or CSUM).
- A byte is accepted on a rising edge where in_valid&&in_ready.
- IDLE: waits; CPU held. start -> LEN.
- LEN:
  - Accepted byte L is the program length.
  - L==0 or L>2**ADDR_W -> ERR.
  - Otherwise store L, clear count and checksum -> DATA.
- DATA:
  - Each accepted byte B:
    - The next cycle has mem_we=1, mem_addr=count, mem_wdata=B.
    - csum ^= B; count++.
  - On acceptance of byte L (count reaches L-1 -> L) -> CSUM.
  - mem_we is a one-cycle pulse per byte; with in_valid held high, one write per cycle (full throughput).
- CSUM:
  - Accepted byte C.
  - C==csum -> RUN; done pulses 1 cycle and cpu_clr_n goes 1, both in the first RUN cycle.
  - C!=csum -> ERR.
- RUN: cpu_clr_n=1, busy=0. start -> LEN, with cpu_clr_n=0 from the next cycle.
- ERR:
  - error=1, cpu_clr_n=0, busy=0.
  - start -> LEN and clears error.
- busy=1 in LEN, DATA and CSUM.
- start while busy is ignored.
- in_valid outside LEN/DATA/CSUM is ignored; no byte is consumed.
- Address wrap: the last write is to address L-1 ≤ 2**ADDR_W-1, so mem_addr never wraps. A length of exactly 2**ADDR_W is legal.
- Reset mid-load:
  - Returns to IDLE in the same edge; no further mem_we.
  - Memory contents are unspecified; the CPU stays held.
- clr and start in the same cycle: reset wins.
- Length is 8-bit; ADDR_W > 8 is not supported.

Decomposition:
- Shared package holds:
  - State encodings IDLE, LEN, DATA, CSUM, RUN, ERR (3-bit).
  - ADDR_W default.
  - Instruction field positions used by CPU and loader tooling: opcode[7:6], funct[5:4], a2[3:2], a1[1:0].
- One natural sub-module, loader_csum: 8-bit XOR accumulator with clear and enable.
- The FSM, counter and write register stay in prog_loader.

Test Plan:
- Good load:
  - Stimulus: start, then stream 0x03,0x4D,0x92,0xC1,0x1E.
  - Response: three mem_we pulses at addr 0,1,2 with data 4D,92,C1; then done=1 for 1 cycle, cpu_clr_n=1, error=0.
- Bad checksum:
  - Stimulus: same stream with checksum 0x1F.
  - Response: three writes; no done; error=1; cpu_clr_n stays 0.
  - Follow-up: start clears error.
- Bad length:
  - Stimulus: length 0x00, and separately 0x21 with ADDR_W=5.
  - Response: immediate ERR, zero mem_we pulses, in_ready=0 afterwards.
- Backpressure/gaps:
  - Stimulus: in_valid toggled 1,0,0,1,… during DATA.
  - Response: writes occur only for accepted bytes, addresses consecutive.
  - Full-size load of 32 bytes writes addr 0..31 with no wrap.
- Reset and reload:
  - Stimulus: clr asserted after 2 of 3 data bytes.
  - Response: state IDLE next cycle, mem_we=0, cpu_clr_n=0.
  - Follow-up: start in RUN drops cpu_clr_n to 0 the next cycle and reloads.
- Ignored start:
  - Stimulus: start pulsed during DATA.
  - Response: no effect on count, address or checksum.
